alpha_tensor_issue_ctrl: RTL and testbench
==========================================

Name: alpha_tensor_issue_ctrl

Overview:
- Issue scheduler between the IDU and the alphaTensor matrix-multiply pipeline (matrix mem read -> preadder -> multiplier -> postadder -> matrix mem write).
- Buffers matrix-mul requests in a small in-order FIFO.
- Tracks in-flight destinations in a scoreboard and issues only when no RAW hazard exists against an unwritten result.
- Applies branch flushes consistently to the queue and to the scoreboard.

Parameters:
- DEPTH_BIT, 8, width of rd/rs1/rs2 matrix-mem indices.
- FIFO_DEPTH, 4, request queue entries (power of two, >=2).
- PIPE_LAT, 3, cycles from issue to matrix-mem write enable (preadder, mul, postadder).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_vld  in  1  IDU request valid.
- req_rdy  out  1  queue can accept; a request is accepted when req_vld & req_rdy.
- req_rd  in  DEPTH_BIT  destination matrix index.
- req_rs1  in  DEPTH_BIT  source 1 index.
- req_rs2  in  DEPTH_BIT  source 2 index.
- bru_vld_0  in  1  branch result valid.
- bru_flush_0  in  1  branch flush; effective flush = bru_vld_0 & bru_flush_0.
- issue_vld  out  1  mul_vld to the datapath.
- issue_rd  out  DEPTH_BIT  rd to the datapath.
- issue_rs1  out  DEPTH_BIT  rs1 to the datapath.
- issue_rs2  out  DEPTH_BIT  rs2 to the datapath.
- stall  out  1  head entry valid but blocked by a hazard.
- busy  out  1  queue non-empty or any scoreboard entry valid.

Behaviour:
- Reset (async, rst_n=0): FIFO empty, pointers 0, scoreboard valids 0.
  - Outputs: req_rdy=1, issue_vld=0, issue_rd/rs1/rs2=0, stall=0, busy=0.
- FIFO: in-order, count 0..FIFO_DEPTH.
  - req_rdy = (count != FIFO_DEPTH).
  - Push and pop in the same cycle while full is allowed only if req_rdy; there is no same-cycle bypass of a full FIFO.
  - Pointers wrap modulo FIFO_DEPTH.
- Issue is combinational from the head.
  - issue_vld = head_valid & ~hazard & ~flush.
  - issue_rd/rs1/rs2 = head fields when issue_vld, else 0.
  - Pop on issue_vld.
  - An empty FIFO never issues; a request accepted in cycle T is issuable at T+1 at the earliest (no fall-through).
- Scoreboard: shift register of PIPE_LAT slots {vld, rd}.
  - Each cycle slot[0] <= {issue_vld, issue_rd} and slot[i] <= slot[i-1]; slot[PIPE_LAT-1] retires.
  - Retirement is simultaneous with the datapath write enable.
- Hazard: hazard = OR over i of slot[i].vld & (slot[i].rd == head.rs1 | slot[i].rd == head.rs2).
  - An op issued at T writes at the end of T+PIPE_LAT, so a dependent op issues at T+PIPE_LAT+1 at the earliest.
  - With PIPE_LAT=3 this is 3 stall cycles.
  - WAW and WAR hazards are not stalled: in-order fixed latency makes them safe.
- stall = head_valid & hazard & ~flush.
- Flush (effective flush high in cycle F):
  - All FIFO entries are discarded at the edge ending F; count=0 and pointers reset to the write pointer.
  - No issue occurs in F.
  - slot[0] (the op issued in F-1, killed in the preadder) is cleared at the same edge it shifts into slot[1]; that op must not appear as valid in slot[1].
  - Older slots are unaffected, since those ops complete.
  - A request presented in F is dropped and req_rdy stays as computed.
- busy = (count != 0) | any slot vld.

Optional Feature:
- ALPHATENSOR_PERF_CNT_EN
  - Defined: adds outputs perf_issue_cnt[31:0] (increments per issue_vld) and perf_stall_cnt[31:0] (increments per stall cycle). Both reset to 0 and wrap at 2^32; flush does not clear them.
  - Undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Independent stream: push {rd=1,rs=2,3}, {rd=4,rs=5,6}, {rd=7,rs=8,9} on consecutive cycles -> issue_vld high on 3 consecutive cycles starting one cycle after the first push; stall never high.
- RAW: push {rd=10,rs=1,2} then {rd=11,rs=10,3} -> first issues at T, second at T+4; stall high T+1..T+3 (3 cycles).
- Full queue: 4 pushes while head is blocked by a hazard -> req_rdy=0 after the 4th; a 5th req_vld is not accepted; req_rdy returns to 1 the cycle after the first pop.
- Flush: issue {rd=20} at T, queue 2 entries, flush at T+1 -> no issue at T+1, FIFO empty at T+2, scoreboard holds no rd=20; a later req {rs1=20} issues with no stall.
- Mid-op reset: rst_n low while 2 queued and 2 in flight -> all outputs 0 immediately (async), busy=0, and an issue is possible again 2 cycles after release.
- Perf counters (macro defined): RAW scenario -> perf_issue_cnt=2, perf_stall_cnt=3.

Source files
------------

// File: rtl/alpha_tensor_issue_ctrl.sv
// alpha_tensor_issue_ctrl
// Issue scheduler feeding the alphaTensor matrix-multiply pipeline.
// Requests wait in an in-order FIFO. The head entry issues only when none of
// the PIPE_LAT in-flight destinations (scoreboard shift register) match its
// sources. A branch flush empties the queue and kills the youngest in-flight op.
// Optional build macro: ALPHATENSOR_PERF_CNT_EN adds issue/stall counters.
module alpha_tensor_issue_ctrl #(
    parameter int DEPTH_BIT  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PIPE_LAT   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_vld,
    output logic                 req_rdy,
    input  logic [DEPTH_BIT-1:0] req_rd,
    input  logic [DEPTH_BIT-1:0] req_rs1,
    input  logic [DEPTH_BIT-1:0] req_rs2,
    input  logic                 bru_vld_0,
    input  logic                 bru_flush_0,
    output logic                 issue_vld,
    output logic [DEPTH_BIT-1:0] issue_rd,
    output logic [DEPTH_BIT-1:0] issue_rs1,
    output logic [DEPTH_BIT-1:0] issue_rs2,
    output logic                 stall,
    output logic                 busy
`ifdef ALPHATENSOR_PERF_CNT_EN
    ,
    output logic [31:0]          perf_issue_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH_BIT-1:0] mem_rd_q  [FIFO_DEPTH];
    logic [DEPTH_BIT-1:0] mem_rs1_q [FIFO_DEPTH];
    logic [DEPTH_BIT-1:0] mem_rs2_q [FIFO_DEPTH];
    logic [DEPTH_BIT-1:0] mem_rd_d  [FIFO_DEPTH];
    logic [DEPTH_BIT-1:0] mem_rs1_d [FIFO_DEPTH];
    logic [DEPTH_BIT-1:0] mem_rs2_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [PIPE_LAT-1:0]  slot_vld_q, slot_vld_d;
    logic [DEPTH_BIT-1:0] slot_rd_q [PIPE_LAT];
    logic [DEPTH_BIT-1:0] slot_rd_d [PIPE_LAT];

    logic                 flush;
    logic                 head_valid;
    logic                 hazard;
    logic                 push;
    logic                 pop;
    logic [DEPTH_BIT-1:0] head_rd, head_rs1, head_rs2;

    assign flush      = bru_vld_0 & bru_flush_0;
    assign head_valid = (count_q != '0);
    assign head_rd    = mem_rd_q[rd_ptr_q];
    assign head_rs1   = mem_rs1_q[rd_ptr_q];
    assign head_rs2   = mem_rs2_q[rd_ptr_q];
    assign req_rdy    = (count_q != CNT_W'(FIFO_DEPTH));
    assign push       = req_vld & req_rdy & ~flush;

    // RAW check of the head sources against every in-flight destination
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            if (slot_vld_q[i] && ((slot_rd_q[i] == head_rs1) || (slot_rd_q[i] == head_rs2)))
                hazard = 1'b1;
        end
    end

    assign issue_vld = head_valid & ~hazard & ~flush;
    assign pop       = issue_vld;
    assign issue_rd  = issue_vld ? head_rd  : '0;
    assign issue_rs1 = issue_vld ? head_rs1 : '0;
    assign issue_rs2 = issue_vld ? head_rs2 : '0;
    assign stall     = head_valid & hazard & ~flush;
    assign busy      = (count_q != '0) | (|slot_vld_q);

    // Queue next state: flush drops everything and realigns the read pointer
    always_comb begin
        mem_rd_d  = mem_rd_q;
        mem_rs1_d = mem_rs1_q;
        mem_rs2_d = mem_rs2_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_rd_d[wr_ptr_q]  = req_rd;
                mem_rs1_d[wr_ptr_q] = req_rs1;
                mem_rs2_d[wr_ptr_q] = req_rs2;
                wr_ptr_d            = wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Scoreboard shift; the op in slot 0 during a flush dies in the preadder
    always_comb begin
        slot_vld_d    = '0;
        slot_rd_d[0]  = issue_rd;
        slot_vld_d[0] = issue_vld;
        for (int i = 1; i < PIPE_LAT; i++) begin
            slot_rd_d[i]  = slot_rd_q[i-1];
            slot_vld_d[i] = slot_vld_q[i-1] & ~((i == 1) & flush);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            slot_vld_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_rd_q[i]  <= '0;
                mem_rs1_q[i] <= '0;
                mem_rs2_q[i] <= '0;
            end
            for (int i = 0; i < PIPE_LAT; i++)
                slot_rd_q[i] <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            slot_vld_q <= slot_vld_d;
            mem_rd_q   <= mem_rd_d;
            mem_rs1_q  <= mem_rs1_d;
            mem_rs2_q  <= mem_rs2_d;
            slot_rd_q  <= slot_rd_d;
        end
    end

`ifdef ALPHATENSOR_PERF_CNT_EN
    logic [31:0] perf_issue_cnt_q, perf_issue_cnt_d;
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

    // Free-running event counters, wrapping, unaffected by flush
    always_comb begin
        perf_issue_cnt_d = perf_issue_cnt_q + {31'd0, issue_vld};
        perf_stall_cnt_d = perf_stall_cnt_q + {31'd0, stall};
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_cnt_q <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_issue_cnt_q <= perf_issue_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_issue_cnt = perf_issue_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_alpha_tensor_issue_ctrl.sv
// Directed testbench for alpha_tensor_issue_ctrl (default parameters).
module tb_alpha_tensor_issue_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_vld;
    logic       req_rdy;
    logic [7:0] req_rd, req_rs1, req_rs2;
    logic       bru_vld_0, bru_flush_0;
    logic       issue_vld;
    logic [7:0] issue_rd, issue_rs1, issue_rs2;
    logic       stall;
    logic       busy;
`ifdef ALPHATENSOR_PERF_CNT_EN
    logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    alpha_tensor_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_vld     (req_vld),
        .req_rdy     (req_rdy),
        .req_rd      (req_rd),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .bru_vld_0   (bru_vld_0),
        .bru_flush_0 (bru_flush_0),
        .issue_vld   (issue_vld),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .stall       (stall),
        .busy        (busy)
`ifdef ALPHATENSOR_PERF_CNT_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [7:0] rd, input logic [7:0] rs1, input logic [7:0] rs2);
        req_vld = v;
        req_rd  = rd;
        req_rs1 = rs1;
        req_rs2 = rs2;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(1'b0, 8'd0, 8'd0, 8'd0);
        bru_vld_0 = 1'b0;
        bru_flush_0 = 1'b0;
        #3;
        checks++;
        if ({req_rdy, issue_vld, issue_rd, issue_rs1, issue_rs2, stall, busy} !== {1'b1, 1'b0, 24'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b rd=%0d rs1=%0d rs2=%0d stall=%b busy=%b, required rdy=1 all else 0",
                     req_rdy, issue_vld, issue_rd, issue_rs1, issue_rs2, stall, busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_independent();
        logic stall_seen;
        stall_seen = 1'b0;
        wait_idle();
        set_req(1'b1, 8'd1, 8'd2, 8'd3);
        checks++;
        if (issue_vld !== 1'b0) begin errors++; $display("FAIL indep_empty: issue_vld=%b required 0", issue_vld); end
        step();
        stall_seen |= stall;
        set_req(1'b1, 8'd4, 8'd5, 8'd6);
        checks++;
        if ({issue_vld, issue_rd, issue_rs1, issue_rs2} !== {1'b1, 8'd1, 8'd2, 8'd3}) begin
            errors++; $display("FAIL indep_first: vld=%b rd=%0d rs1=%0d rs2=%0d required 1/1/2/3", issue_vld, issue_rd, issue_rs1, issue_rs2);
        end
        step();
        stall_seen |= stall;
        set_req(1'b1, 8'd7, 8'd8, 8'd9);
        checks++;
        if ({issue_vld, issue_rd, issue_rs1, issue_rs2} !== {1'b1, 8'd4, 8'd5, 8'd6}) begin
            errors++; $display("FAIL indep_second: vld=%b rd=%0d rs1=%0d rs2=%0d required 1/4/5/6", issue_vld, issue_rd, issue_rs1, issue_rs2);
        end
        step();
        stall_seen |= stall;
        set_req(1'b0, 8'd0, 8'd0, 8'd0);
        checks++;
        if ({issue_vld, issue_rd, issue_rs1, issue_rs2} !== {1'b1, 8'd7, 8'd8, 8'd9}) begin
            errors++; $display("FAIL indep_third: vld=%b rd=%0d rs1=%0d rs2=%0d required 1/7/8/9", issue_vld, issue_rd, issue_rs1, issue_rs2);
        end
        step();
        stall_seen |= stall;
        checks++;
        if ({issue_vld, issue_rd} !== {1'b0, 8'd0}) begin
            errors++; $display("FAIL indep_drain: vld=%b rd=%0d required 0/0", issue_vld, issue_rd);
        end
        checks++;
        if (stall_seen !== 1'b0) begin errors++; $display("FAIL indep_no_stall: stall seen=%b required 0", stall_seen); end
    endtask

    task automatic test_raw();
        set_req(1'b1, 8'd10, 8'd1, 8'd2);
        step();
        set_req(1'b1, 8'd11, 8'd10, 8'd3);
        checks++;
        if ({issue_vld, issue_rd} !== {1'b1, 8'd10}) begin
            errors++; $display("FAIL raw_first: vld=%b rd=%0d required 1/10", issue_vld, issue_rd);
        end
        step();
        set_req(1'b0, 8'd0, 8'd0, 8'd0);
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if ({issue_vld, stall} !== 2'b01) begin
                errors++; $display("FAIL raw_stall_T+%0d: vld=%b stall=%b required 0/1", i, issue_vld, stall);
            end
            step();
        end
        checks++;
        if ({issue_vld, issue_rd, issue_rs1, issue_rs2, stall} !== {1'b1, 8'd11, 8'd10, 8'd3, 1'b0}) begin
            errors++; $display("FAIL raw_second: vld=%b rd=%0d rs1=%0d rs2=%0d stall=%b required 1/11/10/3/0",
                               issue_vld, issue_rd, issue_rs1, issue_rs2, stall);
        end
        step();
        checks++;
        if ({issue_vld, stall} !== 2'b00) begin errors++; $display("FAIL raw_after: vld=%b stall=%b required 0/0", issue_vld, stall); end
    endtask

    task automatic test_full_queue();
        logic [7:0] exp_rd;
        wait_idle();
        set_req(1'b1, 8'd30, 8'd1, 8'd2);
        step();
        set_req(1'b1, 8'd31, 8'd30, 8'd5);
        checks++;
        if ({issue_vld, issue_rd} !== {1'b1, 8'd30}) begin errors++; $display("FAIL full_first: vld=%b rd=%0d required 1/30", issue_vld, issue_rd); end
        step();
        for (int i = 0; i < 3; i++) begin
            exp_rd = 8'd32 + 8'(i);
            set_req(1'b1, exp_rd, 8'd6, 8'd7);
            checks++;
            if ({stall, req_rdy, issue_vld} !== 3'b110) begin
                errors++; $display("FAIL full_fill_%0d: stall=%b rdy=%b vld=%b required 1/1/0", i, stall, req_rdy, issue_vld);
            end
            step();
        end
        set_req(1'b1, 8'd35, 8'd8, 8'd9);
        checks++;
        if ({req_rdy, issue_vld, issue_rd} !== {1'b0, 1'b1, 8'd31}) begin
            errors++; $display("FAIL full_at_depth: rdy=%b vld=%b rd=%0d required 0/1/31", req_rdy, issue_vld, issue_rd);
        end
        step();
        set_req(1'b0, 8'd0, 8'd0, 8'd0);
        checks++;
        if (req_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_back: rdy=%b required 1", req_rdy); end
        for (int i = 0; i < 3; i++) begin
            exp_rd = 8'd32 + 8'(i);
            checks++;
            if ({issue_vld, issue_rd} !== {1'b1, exp_rd}) begin
                errors++; $display("FAIL full_drain_%0d: vld=%b rd=%0d required 1/%0d", i, issue_vld, issue_rd, exp_rd);
            end
            step();
        end
        checks++;
        if (issue_vld !== 1'b0) begin errors++; $display("FAIL full_fifth_dropped: vld=%b rd=%0d required 0", issue_vld, issue_rd); end
    endtask

    task automatic test_flush();
        wait_idle();
        set_req(1'b1, 8'd50, 8'd51, 8'd52);
        step();
        set_req(1'b1, 8'd20, 8'd50, 8'd0);
        step();
        set_req(1'b1, 8'd21, 8'd40, 8'd41);
        step();
        set_req(1'b1, 8'd22, 8'd42, 8'd43);
        step();
        set_req(1'b0, 8'd0, 8'd0, 8'd0);
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL flush_pre_stall: stall=%b required 1", stall); end
        step();
        checks++;
        if ({issue_vld, issue_rd} !== {1'b1, 8'd20}) begin errors++; $display("FAIL flush_issue20: vld=%b rd=%0d required 1/20", issue_vld, issue_rd); end
        step();
        set_req(1'b1, 8'd24, 8'd1, 8'd2);
        bru_vld_0 = 1'b1;
        bru_flush_0 = 1'b1;
        #1;
        checks++;
        if ({issue_vld, stall, req_rdy} !== 3'b001) begin
            errors++; $display("FAIL flush_cycle: vld=%b stall=%b rdy=%b required 0/0/1", issue_vld, stall, req_rdy);
        end
        step();
        bru_vld_0 = 1'b0;
        bru_flush_0 = 1'b0;
        set_req(1'b0, 8'd0, 8'd0, 8'd0);
        checks++;
        if ({busy, issue_vld, req_rdy} !== 3'b001) begin
            errors++; $display("FAIL flush_empty: busy=%b vld=%b rdy=%b required 0/0/1", busy, issue_vld, req_rdy);
        end
        set_req(1'b1, 8'd23, 8'd20, 8'd0);
        step();
        set_req(1'b0, 8'd0, 8'd0, 8'd0);
        checks++;
        if ({issue_vld, issue_rd, stall} !== {1'b1, 8'd23, 1'b0}) begin
            errors++; $display("FAIL flush_dep_issue: vld=%b rd=%0d stall=%b required 1/23/0", issue_vld, issue_rd, stall);
        end
        step();
        checks++;
        if (issue_vld !== 1'b0) begin errors++; $display("FAIL flush_dropped_req: vld=%b rd=%0d required 0", issue_vld, issue_rd); end
    endtask

    task automatic test_midop_reset();
        wait_idle();
        set_req(1'b1, 8'd60, 8'd1, 8'd2);
        step();
        set_req(1'b1, 8'd61, 8'd3, 8'd4);
        step();
        set_req(1'b1, 8'd62, 8'd60, 8'd5);
        step();
        set_req(1'b1, 8'd63, 8'd6, 8'd7);
        step();
        set_req(1'b0, 8'd0, 8'd0, 8'd0);
        checks++;
        if ({stall, busy} !== 2'b11) begin errors++; $display("FAIL midrst_pre: stall=%b busy=%b required 1/1", stall, busy); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({issue_vld, issue_rd, issue_rs1, issue_rs2, stall, busy, req_rdy} !== {1'b0, 24'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL midrst_async: vld=%b rd=%0d stall=%b busy=%b rdy=%b required 0/0/0/0/1",
                               issue_vld, issue_rd, stall, busy, req_rdy);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        set_req(1'b1, 8'd70, 8'd62, 8'd63);
        step();
        set_req(1'b0, 8'd0, 8'd0, 8'd0);
        checks++;
        if ({issue_vld, issue_rd, stall} !== {1'b1, 8'd70, 1'b0}) begin
            errors++; $display("FAIL midrst_reissue: vld=%b rd=%0d stall=%b required 1/70/0", issue_vld, issue_rd, stall);
        end
        step();
        wait_idle();
    endtask

`ifdef ALPHATENSOR_PERF_CNT_EN
    task automatic test_perf();
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        test_raw();
        checks++;
        if ({perf_issue_cnt, perf_stall_cnt} !== {32'd2, 32'd3}) begin
            errors++; $display("FAIL perf_counts: issue=%0d stall=%0d required 2/3", perf_issue_cnt, perf_stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_independent();
        wait_idle();
        test_raw();
        test_full_queue();
        test_flush();
        test_midop_reset();
`ifdef ALPHATENSOR_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
